ct_vfalu_wb_collect: RTL and testbench

Parametrised result collector for the VFALU pipes, replacing the purely combinational EX3 forward mux with a registered writeback stage. It takes SRC_NUM execution-unit result ports (fadd, fcnvt, fspu, …), selects the one-hot valid source, and buffers the selected data and exception flags in a BUF_DEPTH-entry queue. The queue drains to the register-file writeback port under a valid/ready handshake. It also keeps a sticky accumulation of exception flags for fflags update and raises backpressure to issue when the queue is full.

---
 rtl/ct_vfalu_pkg.sv | 25 ++
 rtl/ct_vfalu_wb_fifo.sv | 80 ++++++++
 rtl/ct_vfalu_wb_collect.sv | 121 ++++++++++++
 tb/tb_ct_vfalu_wb_collect.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_vfalu_pkg.sv
// Shared VFALU writeback definitions: flag layout, default widths, queue entry type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   VF_FLAG_W / VF_FLAG_*  exception-flag width and bit positions (NV DZ OF UF NX)
//   VF_DATA_W              default result data width
//   vfalu_entry_t          default-width queue entry {data, flag}
package ct_vfalu_pkg;

   localparam int VF_FLAG_W  = 5;
   localparam int VF_FLAG_NV = 4;
   localparam int VF_FLAG_DZ = 3;
   localparam int VF_FLAG_OF = 2;
   localparam int VF_FLAG_UF = 1;
   localparam int VF_FLAG_NX = 0;

   localparam int VF_DATA_W  = 64;

   typedef struct packed {
      logic [VF_DATA_W-1:0] data;
      logic [VF_FLAG_W-1:0] flag;
   } vfalu_entry_t;

endpackage

// File: rtl/ct_vfalu_wb_fifo.sv
// Circular buffer of DEPTH writeback entries with flush.
// Latency: 1 cycle push-to-head; no bypass when empty.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
//
// Ports:
//   forever_cpuclk, cpurst_b   clock, async active-low reset
//   push, push_dat             write request and entry
//   pop                        retire head (ignored while empty)
//   flush                      discard contents and any push/pop this cycle
//   head_dat                   current head entry (valid while !empty)
//   full, empty                status from registered count
module ct_vfalu_wb_fifo
   import ct_vfalu_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = vfalu_entry_t
) (
   input  logic   forever_cpuclk,
   input  logic   cpurst_b,
   input  logic   push,
   input  entry_t push_dat,
   input  logic   pop,
   input  logic   flush,
   output entry_t head_dat,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             push_ok;
   logic             pop_ok;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (cnt == CNT_FULL);
   assign empty = (cnt == '0);

   // A full queue still accepts a push when the head leaves in the same cycle.
   assign pop_ok  = pop  & ~empty & ~flush;
   assign push_ok = push & (~full | pop_ok) & ~flush;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is not reset; head_dat is meaningless while empty.
   always_ff @(posedge forever_cpuclk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/ct_vfalu_wb_collect.sv
// VFALU result collector: AND-OR select of source results into a registered writeback queue.
// Latency: 1 cycle from src_vld to wb_vld when the queue is empty; 1 entry/cycle throughput.
// Backpressure: wb_ready stalls the head; collect_full tells issue to hold off; overflow drops.
//
// Optional checker macro: VFALU_WB_ONEHOT_CHK_EN (adds sticky onehot_err output).
// Ports:
//   forever_cpuclk, cpurst_b            clock, async active-low reset
//   src_vld/src_data                    per-source result, source i at [i*DATA_W +: DATA_W]
//   src_flag_vld/src_flag               per-source exception flags, source i at [i*FLAG_W +: FLAG_W]
//   rtu_yy_xx_flush                     drop queue contents and this cycle's push/pop
//   wb_vld/wb_ready/wb_data/wb_flag     register-file writeback handshake
//   collect_full                        queue full (registered)
//   fflags_clr/fflags_acc               sticky OR of retired flags, with clear
//   onehot_err                          sticky multi-hot / overflow error (macro only)
module ct_vfalu_wb_collect
   import ct_vfalu_pkg::*;
#(
   parameter int SRC_NUM   = 3,
   parameter int DATA_W    = VF_DATA_W,
   parameter int FLAG_W    = VF_FLAG_W,
   parameter int BUF_DEPTH = 2
) (
   input  logic                      forever_cpuclk,
   input  logic                      cpurst_b,
   input  logic [SRC_NUM-1:0]        src_vld,
   input  logic [SRC_NUM*DATA_W-1:0] src_data,
   input  logic [SRC_NUM-1:0]        src_flag_vld,
   input  logic [SRC_NUM*FLAG_W-1:0] src_flag,
   input  logic                      rtu_yy_xx_flush,
   input  logic                      wb_ready,
   output logic                      wb_vld,
   output logic [DATA_W-1:0]         wb_data,
   output logic [FLAG_W-1:0]         wb_flag,
   output logic                      collect_full,
   input  logic                      fflags_clr,
   output logic [FLAG_W-1:0]         fflags_acc
`ifdef VFALU_WB_ONEHOT_CHK_EN
   ,
   output logic                      onehot_err
`endif
);

   // Entry type at the configured widths; same layout as the package default.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [FLAG_W-1:0] flag;
   } wb_entry_t;

   wb_entry_t sel;
   wb_entry_t head;
   logic      push;
   logic      pop;
   logic      retire;
   logic      q_full;
   logic      q_empty;

   // AND-OR select: a multi-hot input merges rather than picking one source.
   // Flags are masked by their valid here so the queue stores final wb_flag.
   always_comb begin
      sel = '0;
      for (int i = 0; i < SRC_NUM; i++) begin
         if (src_vld[i]) begin
            sel.data = sel.data | src_data[i*DATA_W +: DATA_W];
            if (src_flag_vld[i]) sel.flag = sel.flag | src_flag[i*FLAG_W +: FLAG_W];
         end
      end
   end

   assign push = |src_vld;
   assign pop  = wb_vld & wb_ready;
   // A pop in the flush cycle is discarded, so it does not retire flags either.
   assign retire = pop & ~rtu_yy_xx_flush;

   ct_vfalu_wb_fifo #(
      .DEPTH   (BUF_DEPTH),
      .entry_t (wb_entry_t)
   ) u_fifo (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .push           (push),
      .push_dat       (sel),
      .pop            (pop),
      .flush          (rtu_yy_xx_flush),
      .head_dat       (head),
      .full           (q_full),
      .empty          (q_empty)
   );

   assign wb_vld       = ~q_empty;
   assign wb_data      = head.data;
   assign wb_flag      = head.flag;
   assign collect_full = q_full;

   // Clear takes effect before the OR so a same-cycle retire is kept.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         fflags_acc <= '0;
      end else if (fflags_clr) begin
         fflags_acc <= retire ? wb_flag : '0;
      end else if (retire) begin
         fflags_acc <= fflags_acc | wb_flag;
      end
   end

`ifdef VFALU_WB_ONEHOT_CHK_EN
   logic multi_hot;
   logic overflow;

   assign multi_hot = |(src_vld & (src_vld - SRC_NUM'(1)));
   assign overflow  = push & q_full & ~pop;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         onehot_err <= 1'b0;
      end else if (multi_hot | overflow) begin
         onehot_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ct_vfalu_wb_collect.sv
module tb_ct_vfalu_wb_collect;

   localparam int SRC_NUM   = 3;
   localparam int DATA_W    = 64;
   localparam int FLAG_W    = 5;
   localparam int BUF_DEPTH = 2;

   logic                      clk;
   logic                      rst_b;
   logic [SRC_NUM-1:0]        src_vld;
   logic [SRC_NUM*DATA_W-1:0] src_data;
   logic [SRC_NUM-1:0]        src_flag_vld;
   logic [SRC_NUM*FLAG_W-1:0] src_flag;
   logic                      flush;
   logic                      wb_ready;
   logic                      wb_vld;
   logic [DATA_W-1:0]         wb_data;
   logic [FLAG_W-1:0]         wb_flag;
   logic                      collect_full;
   logic                      fflags_clr;
   logic [FLAG_W-1:0]         fflags_acc;
`ifdef VFALU_WB_ONEHOT_CHK_EN
   logic                      onehot_err;
`endif

   int total;
   int bad;

   ct_vfalu_wb_collect #(
      .SRC_NUM   (SRC_NUM),
      .DATA_W    (DATA_W),
      .FLAG_W    (FLAG_W),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .forever_cpuclk  (clk),
      .cpurst_b        (rst_b),
      .src_vld         (src_vld),
      .src_data        (src_data),
      .src_flag_vld    (src_flag_vld),
      .src_flag        (src_flag),
      .rtu_yy_xx_flush (flush),
      .wb_ready        (wb_ready),
      .wb_vld          (wb_vld),
      .wb_data         (wb_data),
      .wb_flag         (wb_flag),
      .collect_full    (collect_full),
      .fflags_clr      (fflags_clr),
      .fflags_acc      (fflags_acc)
`ifdef VFALU_WB_ONEHOT_CHK_EN
      ,
      .onehot_err      (onehot_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_src;
      src_vld      = '0;
      src_data     = '0;
      src_flag_vld = '0;
      src_flag     = '0;
   endtask

   task automatic put(input int idx, input logic [DATA_W-1:0] d,
                      input logic fv, input logic [FLAG_W-1:0] f);
      idle_src();
      src_vld[idx]                  = 1'b1;
      src_data[idx*DATA_W +: DATA_W] = d;
      src_flag_vld[idx]             = fv;
      src_flag[idx*FLAG_W +: FLAG_W] = f;
   endtask

   task automatic do_reset;
      idle_src();
      flush      = 1'b0;
      wb_ready   = 1'b0;
      fflags_clr = 1'b0;
      rst_b      = 1'b0;
      #7;
      @(negedge clk);
      rst_b = 1'b1;
      step();
   endtask

   task automatic test_reset;
      idle_src();
      flush = 1'b0; wb_ready = 1'b0; fflags_clr = 1'b0;
      rst_b = 1'b0;
      #3;
      if (wb_vld !== 1'b0) begin $display("FAIL reset_wb_vld got=%b exp=0", wb_vld); bad++; end
      total++;
      if (collect_full !== 1'b0) begin $display("FAIL reset_full got=%b exp=0", collect_full); bad++; end
      total++;
      if (fflags_acc !== 5'b0) begin $display("FAIL reset_acc got=%b exp=00000", fflags_acc); bad++; end
      total++;
`ifdef VFALU_WB_ONEHOT_CHK_EN
      if (onehot_err !== 1'b0) begin $display("FAIL reset_err got=%b exp=0", onehot_err); bad++; end
      total++;
`endif
      @(negedge clk);
      rst_b = 1'b1;
      step();
   endtask

   task automatic test_single;
      do_reset();
      wb_ready = 1'b1;
      put(1, 64'h3FF0_0000_0000_0000, 1'b0, 5'b11111);
      step();
      idle_src();
      if (wb_vld !== 1'b1) begin $display("FAIL single_vld got=%b exp=1", wb_vld); bad++; end
      total++;
      if (wb_data !== 64'h3FF0_0000_0000_0000) begin
         $display("FAIL single_data got=%h exp=3ff0000000000000", wb_data); bad++;
      end
      total++;
      if (wb_flag !== 5'b0) begin $display("FAIL single_flag_masked got=%b exp=00000", wb_flag); bad++; end
      total++;
      step();
      if (wb_vld !== 1'b0) begin $display("FAIL single_drain got=%b exp=0", wb_vld); bad++; end
      total++;
      if (fflags_acc !== 5'b0) begin $display("FAIL single_acc got=%b exp=00000", fflags_acc); bad++; end
      total++;
   endtask

   task automatic test_fill_stall;
      do_reset();
      wb_ready = 1'b0;
      put(0, 64'hAAAA, 1'b0, 5'b0);
      step();
      if (collect_full !== 1'b0) begin $display("FAIL fill_one_full got=%b exp=0", collect_full); bad++; end
      total++;
      put(2, 64'hBBBB, 1'b0, 5'b0);
      step();
      if (collect_full !== 1'b1) begin $display("FAIL fill_two_full got=%b exp=1", collect_full); bad++; end
      total++;
      put(1, 64'hCCCC, 1'b0, 5'b0);
      step();
      idle_src();
      if (wb_data !== 64'hAAAA) begin $display("FAIL stall_hold got=%h exp=aaaa", wb_data); bad++; end
      total++;
`ifdef VFALU_WB_ONEHOT_CHK_EN
      if (onehot_err !== 1'b1) begin $display("FAIL overflow_err got=%b exp=1", onehot_err); bad++; end
      total++;
`endif
      wb_ready = 1'b1;
      step();
      if (wb_data !== 64'hBBBB) begin $display("FAIL drain_b got=%h exp=bbbb", wb_data); bad++; end
      total++;
      if (collect_full !== 1'b0) begin $display("FAIL drain_full got=%b exp=0", collect_full); bad++; end
      total++;
      step();
      if (wb_vld !== 1'b0) begin $display("FAIL drain_c_dropped got=%b exp=0", wb_vld); bad++; end
      total++;
   endtask

   task automatic test_full_push_pop;
      do_reset();
      wb_ready = 1'b0;
      put(0, 64'hA1, 1'b0, 5'b0);
      step();
      put(1, 64'hB2, 1'b0, 5'b0);
      step();
      put(2, 64'hC3, 1'b0, 5'b0);
      wb_ready = 1'b1;
      step();
      idle_src();
      if (collect_full !== 1'b1) begin $display("FAIL pp_full got=%b exp=1", collect_full); bad++; end
      total++;
      if (wb_data !== 64'hB2) begin $display("FAIL pp_b got=%h exp=b2", wb_data); bad++; end
      total++;
      step();
      if (wb_data !== 64'hC3 || wb_vld !== 1'b1) begin
         $display("FAIL pp_c got=%h/%b exp=c3/1", wb_data, wb_vld); bad++;
      end
      total++;
      step();
      if (wb_vld !== 1'b0) begin $display("FAIL pp_empty got=%b exp=0", wb_vld); bad++; end
      total++;
`ifdef VFALU_WB_ONEHOT_CHK_EN
      if (onehot_err !== 1'b0) begin $display("FAIL pp_no_err got=%b exp=0", onehot_err); bad++; end
      total++;
`endif
   endtask

   task automatic test_flush;
      do_reset();
      wb_ready = 1'b0;
      put(0, 64'h1111, 1'b0, 5'b0);
      step();
      if (wb_vld !== 1'b1) begin $display("FAIL flush_pre got=%b exp=1", wb_vld); bad++; end
      total++;
      put(1, 64'hDDDD, 1'b0, 5'b0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle_src();
      if (wb_vld !== 1'b0 || collect_full !== 1'b0) begin
         $display("FAIL flush_empty got=%b/%b exp=0/0", wb_vld, collect_full); bad++;
      end
      total++;
      wb_ready = 1'b1;
      step();
      if (wb_vld !== 1'b0) begin $display("FAIL flush_no_ghost got=%b exp=0", wb_vld); bad++; end
      total++;
   endtask

   task automatic test_flags;
      do_reset();
      wb_ready = 1'b0;
      put(0, 64'h1, 1'b1, 5'b00001);
      step();
      put(2, 64'h2, 1'b1, 5'b10000);
      step();
      idle_src();
      if (wb_flag !== 5'b00001) begin $display("FAIL flag_head got=%b exp=00001", wb_flag); bad++; end
      total++;
      wb_ready = 1'b1;
      step();
      if (fflags_acc !== 5'b00001) begin $display("FAIL acc_first got=%b exp=00001", fflags_acc); bad++; end
      total++;
      step();
      if (fflags_acc !== 5'b10001) begin $display("FAIL acc_second got=%b exp=10001", fflags_acc); bad++; end
      total++;
      wb_ready = 1'b0;
      put(1, 64'h3, 1'b1, 5'b00100);
      step();
      idle_src();
      fflags_clr = 1'b1;
      wb_ready   = 1'b1;
      step();
      fflags_clr = 1'b0;
      if (fflags_acc !== 5'b00100) begin $display("FAIL acc_clr_pop got=%b exp=00100", fflags_acc); bad++; end
      total++;
      fflags_clr = 1'b1;
      step();
      fflags_clr = 1'b0;
      if (fflags_acc !== 5'b00000) begin $display("FAIL acc_clr got=%b exp=00000", fflags_acc); bad++; end
      total++;
   endtask

   task automatic test_multi_hot;
      do_reset();
      wb_ready = 1'b0;
      idle_src();
      src_vld                     = 3'b101;
      src_data[0*DATA_W +: DATA_W] = 64'hF0;
      src_data[2*DATA_W +: DATA_W] = 64'h0F;
      src_flag_vld                = 3'b101;
      src_flag[0*FLAG_W +: FLAG_W] = 5'b00001;
      src_flag[2*FLAG_W +: FLAG_W] = 5'b00010;
      step();
      idle_src();
      if (wb_data !== 64'hFF) begin $display("FAIL mh_data got=%h exp=ff", wb_data); bad++; end
      total++;
      if (wb_flag !== 5'b00011) begin $display("FAIL mh_flag got=%b exp=00011", wb_flag); bad++; end
      total++;
`ifdef VFALU_WB_ONEHOT_CHK_EN
      if (onehot_err !== 1'b1) begin $display("FAIL mh_err got=%b exp=1", onehot_err); bad++; end
      total++;
`endif
      wb_ready = 1'b1;
      step();
   endtask

   task automatic test_back_to_back;
      do_reset();
      wb_ready = 1'b1;
      put(0, 64'h100, 1'b0, 5'b0);
      for (int k = 1; k <= 4; k++) begin
         step();
         if (wb_vld !== 1'b1 || wb_data !== 64'h100 + 64'(k - 1) || collect_full !== 1'b0) begin
            $display("FAIL b2b_%0d got=%b/%h/%b exp=1/%h/0", k, wb_vld, wb_data, collect_full,
                     64'h100 + 64'(k - 1));
            bad++;
         end
         total++;
         if (k < 4) put(k % SRC_NUM, 64'h100 + 64'(k), 1'b0, 5'b0);
         else idle_src();
      end
      step();
      if (wb_vld !== 1'b0) begin $display("FAIL b2b_end got=%b exp=0", wb_vld); bad++; end
      total++;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single();
      test_fill_stall();
      test_full_push_pop();
      test_flush();
      test_flags();
      test_multi_hot();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
